// File: rtl/oam_dma_engine.sv
// OAM DMA controller: owns FF46 and copies one 160-byte page into OAM through the MMU DMA port.
// Optional build macro OAM_DMA_FAST_EN shortens the start delay to 1 clock and each byte to 2 clocks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transfer, strobes and dma_active low
// DELAY    | start delay after an FF46 write, dma_active holds its value
// TRANSFER | copying bytes, phase counter sequences read/latch/write
module oam_dma_engine #(
    parameter logic [15:0] REG_ADDR           = 16'hFF46,
    parameter int          START_DELAY_CYCLES = 4,
    parameter int          CYCLES_PER_BYTE    = 4,
    parameter int          OAM_BYTES          = 160,
    parameter logic [15:0] OAM_BASE           = 16'hFE00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_read_en,
    input  logic        bus_write_en,
    output logic [7:0]  bus_rdata,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_read_en,
    output logic        dma_write_en,
    output logic        dma_active,
    input  logic [7:0]  dma_rdata
);

`ifdef OAM_DMA_FAST_EN
    localparam int         DELAY_CYC = 1;
    localparam int         BYTE_CYC  = 2;
    localparam logic [7:0] WR_PHASE  = 8'd1;
`else
    localparam int         DELAY_CYC = START_DELAY_CYCLES;
    localparam int         BYTE_CYC  = CYCLES_PER_BYTE;
    localparam logic [7:0] WR_PHASE  = 8'd2;
`endif
    localparam logic [7:0] DELAY_LOAD = 8'(DELAY_CYC - 1);
    localparam logic [7:0] LAST_PHASE = 8'(BYTE_CYC - 1);
    localparam logic [7:0] PRE_WRITE  = WR_PHASE - 8'd1;
    localparam logic [7:0] LAST_INDEX = 8'(OAM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        TRANSFER = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  src_page, src_page_nxt;
    logic [7:0]  index, index_nxt;
    logic [7:0]  phase, phase_nxt;
    logic [7:0]  dly_cnt, dly_cnt_nxt;
    logic [7:0]  latch, latch_nxt;
    logic [15:0] addr_nxt;
    logic        read_nxt, write_nxt, active_nxt;

    logic        reg_sel;
    logic        reg_wr;
    logic [7:0]  eff_page;
    logic [7:0]  index_inc;

    assign reg_sel   = (bus_addr == REG_ADDR);
    assign reg_wr    = bus_write_en && reg_sel;
    assign bus_rdata = (bus_read_en && reg_sel) ? src_page : 8'hFF;
    // Echo RAM pages E0-FF alias onto C0-DF.
    assign eff_page  = (src_page >= 8'hE0) ? (src_page - 8'h20) : src_page;
    assign index_inc = index + 8'd1;

`ifdef OAM_DMA_FAST_EN
    // Write follows the read by one clock, so read data is forwarded straight through.
    assign dma_wdata = dma_write_en ? dma_rdata : latch;
`else
    assign dma_wdata = latch;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            src_page     <= 8'h00;
            index        <= 8'h00;
            phase        <= 8'h00;
            dly_cnt      <= 8'h00;
            latch        <= 8'h00;
            dma_addr     <= 16'h0000;
            dma_read_en  <= 1'b0;
            dma_write_en <= 1'b0;
            dma_active   <= 1'b0;
        end else begin
            state        <= state_nxt;
            src_page     <= src_page_nxt;
            index        <= index_nxt;
            phase        <= phase_nxt;
            dly_cnt      <= dly_cnt_nxt;
            latch        <= latch_nxt;
            dma_addr     <= addr_nxt;
            dma_read_en  <= read_nxt;
            dma_write_en <= write_nxt;
            dma_active   <= active_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        src_page_nxt = src_page;
        index_nxt    = index;
        phase_nxt    = phase;
        dly_cnt_nxt  = dly_cnt;
        latch_nxt    = latch;
        addr_nxt     = dma_addr;
        read_nxt     = 1'b0;
        write_nxt    = 1'b0;
        active_nxt   = dma_active;

        case (state)
            IDLE: begin
                active_nxt = 1'b0;
            end
            DELAY: begin
                if (dly_cnt == 8'd0) begin
                    state_nxt  = TRANSFER;
                    phase_nxt  = 8'd0;
                    active_nxt = 1'b1;
                    read_nxt   = 1'b1;
                    addr_nxt   = {eff_page, index};
                end else begin
                    dly_cnt_nxt = dly_cnt - 8'd1;
                end
            end
            TRANSFER: begin
                active_nxt = 1'b1;
                if (phase == 8'd1) begin
                    latch_nxt = dma_rdata;
                end
                if (phase == LAST_PHASE) begin
                    index_nxt = index_inc;
                    phase_nxt = 8'd0;
                    if (index == LAST_INDEX) begin
                        state_nxt  = IDLE;
                        active_nxt = 1'b0;
                    end else begin
                        read_nxt = 1'b1;
                        addr_nxt = {eff_page, index_inc};
                    end
                end else begin
                    phase_nxt = phase + 8'd1;
                    if (phase == PRE_WRITE) begin
                        write_nxt = 1'b1;
                        addr_nxt  = OAM_BASE + {8'h00, index};
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A register write restarts the copy and wins over end-of-transfer.
        if (reg_wr) begin
            src_page_nxt = bus_wdata;
            state_nxt    = DELAY;
            dly_cnt_nxt  = DELAY_LOAD;
            index_nxt    = 8'd0;
            phase_nxt    = 8'd0;
            read_nxt     = 1'b0;
            write_nxt    = 1'b0;
            active_nxt   = dma_active;
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine: a memory model plays the MMU, expected DMA traffic is queued
// from a page-level copy model and a negedge monitor pops and compares it.
module tb_oam_dma_engine;

`ifdef OAM_DMA_FAST_EN
    localparam int         DLY        = 1;
    localparam int         CPB        = 2;
    localparam logic [7:0] FIRST_PAGE = 8'h80;
`else
    localparam int         DLY        = 4;
    localparam int         CPB        = 4;
    localparam logic [7:0] FIRST_PAGE = 8'hC0;
`endif
    localparam int NB = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_read_en;
    logic        bus_write_en;
    logic [7:0]  bus_rdata;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_read_en;
    logic        dma_write_en;
    logic        dma_active;
    logic [7:0]  dma_rdata = 8'h00;

    oam_dma_engine dut (
        .clk          (clk),
        .reset        (reset),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_read_en  (bus_read_en),
        .bus_write_en (bus_write_en),
        .bus_rdata    (bus_rdata),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_read_en  (dma_read_en),
        .dma_write_en (dma_write_en),
        .dma_active   (dma_active),
        .dma_rdata    (dma_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (dma_read_en)  dma_rdata <= mem[dma_addr];
        if (dma_write_en) mem[dma_addr] <= dma_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;
    int e0    = 0;
    int rd_seen = 0;
    int wr_seen = 0;
    int run_len = 0;

    logic [15:0] exp_rd [$];
    logic [23:0] exp_wr [$];
    int          exp_len [$];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] eff(input logic [7:0] page);
        return (page >= 8'hE0) ? page - 8'h20 : page;
    endfunction

    // Monitor: compares every DMA strobe and every dma_active run against the queues.
    always @(negedge clk) begin
        logic [23:0] w;
        if (dma_read_en || dma_write_en)
            chk("rd_wr_exclusive", int'(dma_read_en & dma_write_en), 0);
        if (dma_read_en) begin
            rd_seen++;
            chk("read_expected", int'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) chk("read_addr", int'(dma_addr), int'(exp_rd.pop_front()));
        end
        if (dma_write_en) begin
            wr_seen++;
            chk("write_expected", int'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("write_addr", int'(dma_addr), int'(w[23:8]));
                chk("write_data", int'(dma_wdata), int'(w[7:0]));
            end
        end
        if (dma_active) begin
            run_len++;
        end else if (run_len != 0) begin
            chk("active_run_expected", int'(exp_len.size() != 0), 1);
            if (exp_len.size() != 0) chk("active_len", run_len, exp_len.pop_front());
            run_len = 0;
        end
    end

    task automatic push_transfer(input logic [7:0] page);
        logic [15:0] s;
        for (int i = 0; i < NB; i++) begin
            s = {eff(page), 8'(i)};
            exp_rd.push_back(s);
            exp_wr.push_back({16'hFE00 + 16'(i), mem[s]});
        end
    endtask

    task automatic ff46_write(input logic [7:0] page);
        @(negedge clk);
        bus_addr     = 16'hFF46;
        bus_wdata    = page;
        bus_write_en = 1'b1;
        @(posedge clk);
        #1;
        bus_write_en = 1'b0;
        bus_addr     = 16'h0000;
        e0 = cyc;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        wait_until(e0 + DLY + NB * CPB + 2);
        chk("reads_drained", exp_rd.size(), 0);
        chk("writes_drained", exp_wr.size(), 0);
        chk("runs_drained", exp_len.size(), 0);
        chk("idle_active", int'(dma_active), 0);
    endtask

    task automatic check_ff46(input string name, input logic [7:0] req);
        bus_read_en = 1'b1;
        bus_addr    = 16'hFF46;
        #1;
        chk(name, int'(bus_rdata), int'(req));
        bus_read_en = 1'b0;
        bus_addr    = 16'h0000;
    endtask

    task automatic oam_check(input logic [7:0] page, input int upto);
        for (int i = 0; i < upto; i++)
            chk("oam_byte", int'(mem[16'hFE00 + 16'(i)]), int'(mem[{eff(page), 8'(i)}]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rd0, wr0;
        logic [7:0] p1, p2;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < NB; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;

        reset = 1'b1;
        bus_addr = 16'h0000;
        bus_wdata = 8'h00;
        bus_read_en = 1'b0;
        bus_write_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", int'(dma_active), 0);
        chk("rst_read_en", int'(dma_read_en), 0);
        chk("rst_write_en", int'(dma_write_en), 0);
        chk("rst_addr", int'(dma_addr), 0);
        chk("rst_wdata", int'(dma_wdata), 0);
        check_ff46("rst_ff46", 8'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rdata_no_strobe", int'(bus_rdata), 8'hFF);
        bus_read_en = 1'b1;
        bus_addr = 16'hFF47;
        #1;
        chk("rdata_other_addr", int'(bus_rdata), 8'hFF);
        bus_read_en = 1'b0;

        // Uninterrupted copy with start latency and strobe counts.
        rd0 = rd_seen;
        wr0 = wr_seen;
        ff46_write(FIRST_PAGE);
        push_transfer(FIRST_PAGE);
        exp_len.push_back(NB * CPB);
        n = 0;
        while (!dma_active && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("start_latency", n, DLY);
        wait_done();
        chk("reads_seen", rd_seen - rd0, NB);
        chk("writes_seen", wr_seen - wr0, NB);
        oam_check(FIRST_PAGE, NB);
        check_ff46("ff46_first", FIRST_PAGE);

        // Echo-RAM page aliasing.
        ff46_write(8'hE1);
        push_transfer(8'hE1);
        exp_len.push_back(NB * CPB);
        check_ff46("ff46_e1", 8'hE1);
        wait_done();
        oam_check(8'hE1, NB);

        for (int k = 0; k < 3; k++) begin
            p1 = 8'($urandom_range(0, 255));
            ff46_write(p1);
            push_transfer(p1);
            exp_len.push_back(NB * CPB);
            wait_done();
            check_ff46("ff46_random", p1);
        end

        // Restart after 50 bytes; lands on byte 49's final phase.
        ff46_write(FIRST_PAGE);
        push_transfer(FIRST_PAGE);
        wait_until(e0 + DLY + 50 * CPB - 1);
        ff46_write(8'hD0);
        exp_rd.delete();
        exp_wr.delete();
        push_transfer(8'hD0);
        exp_len.push_back(50 * CPB + DLY + NB * CPB);
        oam_check(FIRST_PAGE, 50);
        wait_done();
        oam_check(8'hD0, NB);

        // Restart exactly on the final phase of byte 159.
        p1 = 8'($urandom_range(0, 255));
        p2 = 8'($urandom_range(0, 255));
        ff46_write(p1);
        push_transfer(p1);
        wait_until(e0 + DLY + NB * CPB - 1);
        ff46_write(p2);
        exp_rd.delete();
        exp_wr.delete();
        push_transfer(p2);
        exp_len.push_back(NB * CPB + DLY + NB * CPB);
        wait_done();
        check_ff46("ff46_restart_last", p2);

        // Asynchronous reset while byte 80's read strobe is up.
        p1 = 8'($urandom_range(0, 255));
        ff46_write(p1);
        push_transfer(p1);
        exp_len.push_back(80 * CPB);
        wait_until(e0 + DLY + 80 * CPB);
        #1;
        reset = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        #1;
        chk("midrst_read_en", int'(dma_read_en), 0);
        chk("midrst_write_en", int'(dma_write_en), 0);
        chk("midrst_active", int'(dma_active), 0);
        check_ff46("midrst_ff46", 8'h00);
        wr0 = wr_seen;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("post_rst_writes", wr_seen - wr0, 0);
        chk("post_rst_active", int'(dma_active), 0);
        chk("post_rst_runs", exp_len.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
